inst_fetch: RTL
===============

Name: inst_fetch

Overview:
Instruction fetch unit on the producer side of the instruction decoder's `inst` input. It keeps the fetch PC and issues word requests to instruction memory, up to DEPTH outstanding. Returned words are buffered in an in-order queue. Each instruction goes to the decoder with its PC over a valid/ready handshake. A redirect input (branch/jump) flushes the queue and discards in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
DEPTH, 4, queue entries and maximum outstanding requests combined (power of 2, >= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  request valid
imem_addr  output  32  word-aligned fetch address
imem_gnt  input  1  request accepted this cycle when imem_req & imem_gnt
imem_rvalid  input  1  response valid; responses in grant order, at least 1 cycle after grant
imem_rdata  input  32  instruction word
inst_valid  output  1  queue head valid
inst_ready  input  1  decoder accepts head
inst  output  32  head instruction word
inst_pc  output  32  head instruction PC
redir_valid  input  1  redirect request
redir_pc  input  32  redirect target

Behaviour:
- Reset state (async, on rst_n low):
  - fetch_pc = resp_pc = RESET_PC.
  - Queue empty; outstanding = 0; drop_cnt = 0.
  - inst_valid = 0, imem_req = 0 while rst_n low, inst/inst_pc = 0.
- Counters: occupancy, outstanding and drop_cnt are $clog2(DEPTH)+1 bits. PCs wrap modulo 2^32.
- Request generation (combinational):
  - imem_req = !redir_valid && (occupancy + outstanding < DEPTH).
  - imem_addr = fetch_pc.
  - On grant: fetch_pc += 4, outstanding += 1.
- Response handling (imem_rvalid):
  - Always outstanding -= 1.
  - If drop_cnt > 0 or redir_valid the same cycle: word discarded; if drop_cnt > 0, drop_cnt -= 1.
  - Otherwise push {imem_rdata, resp_pc} into the queue and resp_pc += 4.
  - imem_rvalid with outstanding == 0 is a protocol violation: ignored, counters unchanged.
- Output:
  - inst_valid = (occupancy != 0); inst/inst_pc = head entry.
  - Pop on inst_valid & inst_ready.
  - No bypass: a response appears on inst_valid the cycle after imem_rvalid (latency 1).
  - Push and pop in the same cycle keep occupancy unchanged. Overflow is impossible by the credit rule.
- Redirect (redir_valid = 1):
  - Target: fetch_pc = resp_pc = {redir_pc[31:2], 2'b00}; misaligned low bits are forced to 0.
  - Queue cleared. A pop in the same cycle counts as consumed; the decoder owns that word.
  - drop_cnt = outstanding - imem_rvalid, i.e. every still-pending response is discarded. This includes responses already being dropped from an earlier redirect.
  - No grant can occur this cycle because imem_req = 0.
  - Back-to-back redirects: the last one wins; the drop count is recomputed each cycle.
- After a redirect, requests resume the next cycle from the new target. Credit still counts outstanding responses that will be dropped.
- Reset mid-operation: all state returns to reset values immediately. The instruction memory must be reset together (no stale responses expected).
- State machine: implicit. Modes are RUN (drop_cnt == 0) and DRAIN (drop_cnt > 0). RUN → DRAIN on a redirect with pending responses. DRAIN → RUN when the last dropped response returns.

Test Plan:
1. Reset release, imem_gnt = 1, rvalid 1 cycle after each grant, inst_ready = 1 → imem_addr 0x0, 0x4, 0x8…; inst_pc 0x0, 0x4, 0x8… with matching inst, one per cycle, no gaps.
2. inst_ready = 0, memory always granting → exactly 4 grants (addrs 0x0–0xC), then imem_req = 0. inst_valid held with inst_pc = 0x0. Raising inst_ready drains 0x0–0xC in order, and requests resume at 0x10.
3. Two requests outstanding, 2-cycle memory latency, redir_valid with redir_pc = 0x100 → queue empties next cycle. Next two responses dropped. First delivered inst_pc = 0x100; imem_addr = 0x100 on the cycle after the redirect.
4. redir_pc = 0x103 → imem_addr = 0x100 and inst_pc = 0x100. imem_rvalid coinciding with redir_valid → that word never appears on inst.
5. Redirect to 0x200, then redirect to 0x300 before the drains finish → no word with PC 0x2xx is ever delivered; first inst_pc = 0x300.
6. rst_n pulled low mid-stream (queue of 3, 1 outstanding) → inst_valid = 0 and imem_req = 0 immediately (asynchronous). After release, imem_addr = RESET_PC.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decoder
// handshake and branch/jump redirect, seen from the fetch unit (master).
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redir_valid;
    logic [31:0] redir_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redir_valid, redir_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redir_valid, redir_pc
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: credit-limited word requests, in-order response
// queue feeding the decoder, redirect flush with drain of in-flight responses.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_r, resp_pc_r;
    logic [CW-1:0] occ_r, outst_r, drop_r;
    logic [AW-1:0] wptr_r, rptr_r;
    logic [31:0]   word_q_r [DEPTH];
    logic [31:0]   pc_q_r   [DEPTH];

    logic [31:0]   fetch_pc_nxt_s, resp_pc_nxt_s;
    logic [CW-1:0] occ_nxt_s, outst_nxt_s, drop_nxt_s;
    logic [AW-1:0] wptr_nxt_s, rptr_nxt_s;
    logic [CW:0]   credit_sum_s;
    logic          req_s, grant_s, rsp_s, discard_s, push_s, pop_s, inst_valid_s;
    logic [31:0]   redir_tgt_s;

    // Queue entries plus in-flight requests never exceed DEPTH, so a push can never overflow.
    assign credit_sum_s = {1'b0, occ_r} + {1'b0, outst_r};
    assign req_s        = rst_n && !bus.redir_valid && (credit_sum_s < DEPTH_C);
    assign grant_s      = req_s && bus.imem_gnt;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_s        = bus.imem_rvalid && (outst_r != {CW{1'b0}});
    assign discard_s    = rsp_s && ((drop_r != {CW{1'b0}}) || bus.redir_valid);
    assign push_s       = rsp_s && !discard_s;
    assign inst_valid_s = (occ_r != {CW{1'b0}});
    assign pop_s        = inst_valid_s && bus.inst_ready;
    assign redir_tgt_s  = bus.redir_pc & 32'hFFFF_FFFC;

    assign bus.imem_req   = req_s;
    assign bus.imem_addr  = fetch_pc_r;
    assign bus.inst_valid = inst_valid_s;
    assign bus.inst       = word_q_r[rptr_r];
    assign bus.inst_pc    = pc_q_r[rptr_r];

    // Next-state for PCs, credit/drop counters and queue pointers
    always_comb begin
        fetch_pc_nxt_s = fetch_pc_r;
        resp_pc_nxt_s  = resp_pc_r;
        occ_nxt_s      = occ_r;
        drop_nxt_s     = drop_r;
        wptr_nxt_s     = wptr_r;
        rptr_nxt_s     = rptr_r;

        if (grant_s && !rsp_s) begin
            outst_nxt_s = outst_r + CW'(1'b1);
        end else if (!grant_s && rsp_s) begin
            outst_nxt_s = outst_r - CW'(1'b1);
        end else begin
            outst_nxt_s = outst_r;
        end

        if (bus.redir_valid) begin
            // No grant is possible here, so every still-pending response gets dropped.
            fetch_pc_nxt_s = redir_tgt_s;
            resp_pc_nxt_s  = redir_tgt_s;
            occ_nxt_s      = {CW{1'b0}};
            drop_nxt_s     = outst_nxt_s;
            wptr_nxt_s     = {AW{1'b0}};
            rptr_nxt_s     = {AW{1'b0}};
        end else begin
            fetch_pc_nxt_s = grant_s ? (fetch_pc_r + 32'd4) : fetch_pc_r;
            drop_nxt_s     = (rsp_s && (drop_r != {CW{1'b0}})) ? (drop_r - CW'(1'b1)) : drop_r;
            resp_pc_nxt_s  = push_s ? (resp_pc_r + 32'd4) : resp_pc_r;
            wptr_nxt_s     = push_s ? (wptr_r + AW'(1'b1)) : wptr_r;
            rptr_nxt_s     = pop_s ? (rptr_r + AW'(1'b1)) : rptr_r;
            if (push_s && !pop_s) begin
                occ_nxt_s = occ_r + CW'(1'b1);
            end else if (!push_s && pop_s) begin
                occ_nxt_s = occ_r - CW'(1'b1);
            end else begin
                occ_nxt_s = occ_r;
            end
        end
    end

    // State registers and queue storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            occ_r      <= {CW{1'b0}};
            outst_r    <= {CW{1'b0}};
            drop_r     <= {CW{1'b0}};
            wptr_r     <= {AW{1'b0}};
            rptr_r     <= {AW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                word_q_r[i] <= 32'h0;
                pc_q_r[i]   <= 32'h0;
            end
        end else begin
            fetch_pc_r <= fetch_pc_nxt_s;
            resp_pc_r  <= resp_pc_nxt_s;
            occ_r      <= occ_nxt_s;
            outst_r    <= outst_nxt_s;
            drop_r     <= drop_nxt_s;
            wptr_r     <= wptr_nxt_s;
            rptr_r     <= rptr_nxt_s;
            if (push_s) begin
                word_q_r[wptr_r] <= bus.imem_rdata;
                pc_q_r[wptr_r]   <= resp_pc_r;
            end
        end
    end
endmodule
